// File: rtl/min_max_pkg.sv
// Shared types and constant helpers for the streaming min/max tracker.
// Limit helpers return a 64-bit value; callers keep the low WIDTH bits.
package min_max_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LIMIT_W = 64;

  function automatic int idx_width(input int beats, input int lanes);
    int total;
    int w;
    total = beats * lanes;
    w     = 1;
    while ((1 << w) < total) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic logic [LIMIT_W-1:0] type_max(input int width, input bit is_signed);
    if (is_signed) begin
      return (64'd1 << (width - 1)) - 64'd1;
    end else begin
      return (64'd1 << width) - 64'd1;
    end
  endfunction

  function automatic logic [LIMIT_W-1:0] type_min(input int width, input bit is_signed);
    if (is_signed) begin
      return 64'd1 << (width - 1);
    end else begin
      return 64'd0;
    end
  endfunction

endpackage

// File: rtl/min_max_lane_reduce.sv
// Combinational reduction of one beat to its extremes and their lane numbers.
// Linear chain with strict compares so the lowest lane wins on ties.
module min_max_lane_reduce #(
  parameter int WIDTH  = 16,
  parameter int LANES  = 2,
  parameter int SIGNED = 0,
  parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]       o_min,
  output logic [LANE_W-1:0]      o_min_lane,
  output logic [WIDTH-1:0]       o_max,
  output logic [LANE_W-1:0]      o_max_lane
);

  function automatic logic smp_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) begin
      return $signed(a) < $signed(b);
    end else begin
      return a < b;
    end
  endfunction

  logic [WIDTH-1:0]  w_min;
  logic [WIDTH-1:0]  w_max;
  logic [LANE_W-1:0] w_min_lane;
  logic [LANE_W-1:0] w_max_lane;

  // Walk lanes upward, replacing the candidate only on a strict improvement.
  always_comb begin
    w_min      = i_data[WIDTH-1:0];
    w_max      = i_data[WIDTH-1:0];
    w_min_lane = '0;
    w_max_lane = '0;
    for (int k = 1; k < LANES; k++) begin
      if (smp_lt(i_data[k*WIDTH +: WIDTH], w_min)) begin
        w_min      = i_data[k*WIDTH +: WIDTH];
        w_min_lane = LANE_W'(k);
      end else begin
        w_min_lane = w_min_lane;
      end
      if (smp_lt(w_max, i_data[k*WIDTH +: WIDTH])) begin
        w_max      = i_data[k*WIDTH +: WIDTH];
        w_max_lane = LANE_W'(k);
      end else begin
        w_max_lane = w_max_lane;
      end
    end
  end

  assign o_min      = w_min;
  assign o_max      = w_max;
  assign o_min_lane = w_min_lane;
  assign o_max_lane = w_max_lane;

endmodule

// File: rtl/min_max_tracker.sv
// Streaming min/max finder over a block of BEATS beats of LANES samples,
// tracking each extreme and its flat index (beat*LANES + lane).
module min_max_tracker
  import min_max_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANES  = 2,
  parameter int BEATS  = 4,
  parameter int SIGNED = 0,
  parameter int IDXW   = idx_width(BEATS, LANES)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_in_valid,
  input  logic [LANES*WIDTH-1:0] i_in_data,
  output logic                   o_in_ready,
  output logic [WIDTH-1:0]       o_max_out,
  output logic [WIDTH-1:0]       o_min_out,
  output logic [IDXW-1:0]        o_max_idx,
  output logic [IDXW-1:0]        o_min_idx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [LIMIT_W-1:0] MAX_FULL = type_max(WIDTH, SIGNED != 0);
  localparam logic [LIMIT_W-1:0] MIN_FULL = type_min(WIDTH, SIGNED != 0);
  localparam logic [WIDTH-1:0]   MAX_LIM  = MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]   MIN_LIM  = MIN_FULL[WIDTH-1:0];

  function automatic logic smp_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) begin
      return $signed(a) < $signed(b);
    end else begin
      return a < b;
    end
  endfunction

  state_e            r_state;
  logic [CW-1:0]     r_beat_cnt;
  logic [WIDTH-1:0]  r_min;
  logic [WIDTH-1:0]  r_max;
  logic [IDXW-1:0]   r_min_idx;
  logic [IDXW-1:0]   r_max_idx;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;

  logic [WIDTH-1:0]  w_beat_min;
  logic [WIDTH-1:0]  w_beat_max;
  logic [LANE_W-1:0] w_beat_min_lane;
  logic [LANE_W-1:0] w_beat_max_lane;
  logic [IDXW-1:0]   w_min_idx;
  logic [IDXW-1:0]   w_max_idx;
  logic              w_accept;
  logic              w_last;

  min_max_lane_reduce #(
    .WIDTH  (WIDTH),
    .LANES  (LANES),
    .SIGNED (SIGNED),
    .LANE_W (LANE_W)
  ) u_reduce (
    .i_data     (i_in_data),
    .o_min      (w_beat_min),
    .o_min_lane (w_beat_min_lane),
    .o_max      (w_beat_max),
    .o_max_lane (w_beat_max_lane)
  );

  assign w_accept  = i_in_valid & r_in_ready;
  assign w_last    = (r_beat_cnt == CW'(BEATS - 1));
  assign w_min_idx = IDXW'(r_beat_cnt) * IDXW'(LANES) + IDXW'(w_beat_min_lane);
  assign w_max_idx = IDXW'(r_beat_cnt) * IDXW'(LANES) + IDXW'(w_beat_max_lane);

  // FSM, beat counter and accumulator merge; start wins over any same-cycle beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_min      <= '0;
      r_max      <= '0;
      r_min_idx  <= '0;
      r_max_idx  <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (i_start) begin
      r_state    <= ST_RUN;
      r_beat_cnt <= '0;
      r_min      <= MAX_LIM;
      r_max      <= MIN_LIM;
      r_min_idx  <= '0;
      r_max_idx  <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            // Strict compares keep the existing accumulator on ties.
            if (smp_lt(w_beat_min, r_min)) begin
              r_min     <= w_beat_min;
              r_min_idx <= w_min_idx;
            end
            if (smp_lt(r_max, w_beat_max)) begin
              r_max     <= w_beat_max;
              r_max_idx <= w_max_idx;
            end
            if (w_last) begin
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_min_out  = r_min;
  assign o_max_out  = r_max;
  assign o_min_idx  = r_min_idx;
  assign o_max_idx  = r_max_idx;

endmodule
